// File: rtl/display_scan_if.sv
// Signal bundle between the robot core (master) and the 7-segment scan controller (slave).
// LOAD is a one-cycle strobe with no ready; the controller accepts it in any cycle.
interface display_scan_if;
    logic        ERRO;
    logic        LOAD;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic        D1, D2, D3, D4;
    logic        SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P;
    logic        FRAME;

    modport master (
        output ERRO, LOAD, VALUE, DP_IN,
        input  D1, D2, D3, D4,
        input  SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P,
        input  FRAME
    );

    modport slave (
        input  ERRO, LOAD, VALUE, DP_IN,
        output D1, D2, D3, D4,
        output SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P,
        output FRAME
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller with frame-aligned value/error updates.
// Optional macro DISP_BLINK_ERR_EN makes the error "E" blink every BLINK_FRAMES frames.
module display_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic          CLK,
    input  logic          RST_N,
    display_scan_if.slave bus
);
    localparam int CW = $clog2(PRESCALE);

    if (PRESCALE < 4 || BLANK_CYC < 1 || BLANK_CYC > PRESCALE - 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("display_scan_ctrl: illegal parameter set");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   pend_q, pend_d;
    logic [19:0]   shad_q, shad_d;
    logic          erro_s1_q, erro_s2_q;
    logic          err_q, err_d;
    logic [3:0]    dig_q, dig_d;
    logic [6:0]    seg_q, seg_d;
    logic          segp_q, segp_d;
    logic          frame_q, frame_d;

    logic          slot_end;
    logic          frame_start;
    logic [3:0]    nib;
    logic          dp_bit;
    logic          dig_en;
    logic          err_vis;

    // Active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_end    = (cnt_q == CW'(PRESCALE - 1));
        frame_start = slot_end && (idx_q == 2'd3);
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        // pend_d already carries a coincident LOAD, so it wins at frame start
        pend_d      = bus.LOAD ? {bus.VALUE, bus.DP_IN} : pend_q;
        shad_d      = frame_start ? pend_d : shad_q;
        err_d       = frame_start ? erro_s2_q : err_q;
        frame_d     = frame_start;

        nib    = 4'h0;
        dp_bit = 1'b0;
        case (idx_q)
            2'd0: begin nib = shad_q[19:16]; dp_bit = shad_q[3]; end
            2'd1: begin nib = shad_q[15:12]; dp_bit = shad_q[2]; end
            2'd2: begin nib = shad_q[11:8];  dp_bit = shad_q[1]; end
            default: begin nib = shad_q[7:4]; dp_bit = shad_q[0]; end
        endcase

        dig_en = 1'b1;
        seg_d  = ~hex7(nib);
        segp_d = ~dp_bit;
        if (err_q) begin
            if (idx_q == 2'd0) begin
                seg_d  = ~7'h79;
                segp_d = 1'b1;
                dig_en = err_vis;
            end else begin
                seg_d  = 7'h7F;
                segp_d = 1'b1;
                dig_en = 1'b0;
            end
        end

        // Segments change while all digits are blanked, so no ghosting across slots
        dig_d = (dig_en && (cnt_q >= CW'(BLANK_CYC))) ? ~(4'b1000 >> idx_q) : 4'b1111;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            pend_q    <= '0;
            shad_q    <= '0;
            erro_s1_q <= 1'b0;
            erro_s2_q <= 1'b0;
            err_q     <= 1'b0;
            dig_q     <= 4'b1111;
            seg_q     <= 7'h7F;
            segp_q    <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            shad_q    <= shad_d;
            erro_s1_q <= bus.ERRO;
            erro_s2_q <= erro_s1_q;
            err_q     <= err_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
            segp_q    <= segp_d;
            frame_q   <= frame_d;
        end
    end

`ifdef DISP_BLINK_ERR_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_dark_q, blink_dark_d;

    // Restarts on entry (err_q still low) so the first error phase is visible
    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        blink_dark_d = blink_dark_q;
        if (frame_start) begin
            if (!(err_q && erro_s2_q)) begin
                blink_cnt_d  = '0;
                blink_dark_d = 1'b0;
            end else if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d  = '0;
                blink_dark_d = ~blink_dark_q;
            end else begin
                blink_cnt_d  = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt_q  <= '0;
            blink_dark_q <= 1'b0;
        end else begin
            blink_cnt_q  <= blink_cnt_d;
            blink_dark_q <= blink_dark_d;
        end
    end

    assign err_vis = ~blink_dark_q;
`else
    assign err_vis = 1'b1;
`endif

    assign bus.D1    = dig_q[3];
    assign bus.D2    = dig_q[2];
    assign bus.D3    = dig_q[1];
    assign bus.D4    = dig_q[0];
    assign bus.SEG_A = seg_q[0];
    assign bus.SEG_B = seg_q[1];
    assign bus.SEG_C = seg_q[2];
    assign bus.SEG_D = seg_q[3];
    assign bus.SEG_E = seg_q[4];
    assign bus.SEG_F = seg_q[5];
    assign bus.SEG_G = seg_q[6];
    assign bus.SEG_P = segp_q;
    assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: checks every cycle of each frame against
// hand-built digit/segment expectations (PRESCALE=8, BLANK_CYC=2, BLINK_FRAMES=2).
module tb_display_scan_ctrl;
    localparam int PRESCALE     = 8;
    localparam int BLANK_CYC    = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = 4 * PRESCALE;
`ifdef DISP_BLINK_ERR_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    display_scan_if bus();

    display_scan_ctrl #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYC    (BLANK_CYC),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] dig_obs;
    logic [7:0] seg_obs;
    assign dig_obs = {bus.D1, bus.D2, bus.D3, bus.D4};
    assign seg_obs = {bus.SEG_P, bus.SEG_G, bus.SEG_F, bus.SEG_E,
                      bus.SEG_D, bus.SEG_C, bus.SEG_B, bus.SEG_A};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Active-high {g,f,e,d,c,b,a} for each hex digit
    function automatic logic [6:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: hex_pat = 7'b0111111;
            4'h1: hex_pat = 7'b0000110;
            4'h2: hex_pat = 7'b1011011;
            4'h3: hex_pat = 7'b1001111;
            4'h4: hex_pat = 7'b1100110;
            4'h5: hex_pat = 7'b1101101;
            4'h6: hex_pat = 7'b1111101;
            4'h7: hex_pat = 7'b0000111;
            4'h8: hex_pat = 7'b1111111;
            4'h9: hex_pat = 7'b1101111;
            4'hA: hex_pat = 7'b1110111;
            4'hB: hex_pat = 7'b1111100;
            4'hC: hex_pat = 7'b0111001;
            4'hD: hex_pat = 7'b1011110;
            4'hE: hex_pat = 7'b1111001;
            default: hex_pat = 7'b1110001;
        endcase
    endfunction

    // Starts at the negedge where the frame's counter is 0 (FRAME high, or just out of
    // reset) and ends at the negedge where the next FRAME is high.
    // mode: 0 normal, 1 error "E" visible, 2 error "E" dark.
    task automatic run_frame(input string name, input logic [19:0] exp_v, input int mode,
                             input int la_c, input logic [19:0] la_v,
                             input int lb_c, input logic [19:0] lb_v,
                             input int e_c, input logic e_v);
        for (int c = 1; c <= FRAME_CYC; c++) begin
            int p;
            int idx;
            int cn;
            logic       lit;
            logic [3:0] on_vec;
            logic [3:0] ed;
            logic [7:0] es;
            logic [3:0] nib;
            logic       dpb;

            if (c - 1 == la_c) begin
                bus.LOAD = 1'b1;
                {bus.VALUE, bus.DP_IN} = la_v;
            end else if (c - 1 == lb_c) begin
                bus.LOAD = 1'b1;
                {bus.VALUE, bus.DP_IN} = lb_v;
            end else begin
                bus.LOAD = 1'b0;
            end
            if (c - 1 == e_c) bus.ERRO = e_v;

            @(posedge CLK);
            @(negedge CLK);

            p   = c - 1;
            idx = p / PRESCALE;
            cn  = p % PRESCALE;
            lit = (cn >= BLANK_CYC);
            case (idx)
                0: on_vec = 4'b0111;
                1: on_vec = 4'b1011;
                2: on_vec = 4'b1101;
                default: on_vec = 4'b1110;
            endcase
            nib = exp_v[19 - 4 * idx -: 4];
            dpb = exp_v[3 - idx];

            ed = 4'b1111;
            es = {~dpb, ~hex_pat(nib)};
            if (mode == 0) begin
                if (lit) ed = on_vec;
            end else if (idx == 0) begin
                es = 8'b10000110;
                if (lit && mode == 1) ed = on_vec;
            end else begin
                es = 8'hFF;
            end

            check_eq($sformatf("%s.c%0d.dig", name, c), {4'h0, dig_obs}, {4'h0, ed});
            check_eq($sformatf("%s.c%0d.seg", name, c), seg_obs, es);
            check_eq($sformatf("%s.c%0d.frame", name, c), {7'h0, bus.FRAME},
                     {7'h0, (c == FRAME_CYC)});
        end
        bus.LOAD = 1'b0;
    endtask

    initial begin
        bus.ERRO  = 1'b0;
        bus.LOAD  = 1'b0;
        bus.VALUE = 16'h0;
        bus.DP_IN = 4'h0;
        RST_N     = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst.dig", {4'h0, dig_obs}, 8'h0F);
        check_eq("rst.seg", seg_obs, 8'hFF);
        check_eq("rst.frame", {7'h0, bus.FRAME}, 8'h00);
        RST_N = 1'b1;

        run_frame("idle0", 20'h0, 0, -1, 20'h0, -1, 20'h0, -1, 1'b0);
        run_frame("idle1", 20'h0, 0, -1, 20'h0, -1, 20'h0, -1, 1'b0);
        run_frame("ld_mid", 20'h0, 0, 10, {16'h12AF, 4'b0100}, -1, 20'h0, -1, 1'b0);
        run_frame("show_12af", {16'h12AF, 4'b0100}, 0,
                  10, {16'h5555, 4'h0}, 31, {16'h3333, 4'h0}, -1, 1'b0);
        run_frame("fs_win", {16'h3333, 4'h0}, 0, -1, 20'h0, -1, 20'h0, 2, 1'b1);
        run_frame("err0", 20'h0, 1, -1, 20'h0, -1, 20'h0, -1, 1'b0);
        run_frame("err1", 20'h0, 1, 20, {16'hC0DE, 4'b1010}, -1, 20'h0, -1, 1'b0);
        run_frame("err2", 20'h0, BLINK_ON ? 2 : 1, -1, 20'h0, -1, 20'h0, 6, 1'b0);
        run_frame("restore", {16'hC0DE, 4'b1010}, 0, 12, {16'h4B69, 4'b0001}, -1, 20'h0, -1, 1'b0);
        run_frame("show_4b69", {16'h4B69, 4'b0001}, 0, 15, {16'h7788, 4'b1111}, -1, 20'h0, -1, 1'b0);
        run_frame("show_7788", {16'h7788, 4'b1111}, 0, -1, 20'h0, -1, 20'h0, -1, 1'b0);

        // Into slot 2 with D3 lit, then reset asynchronously between clock edges
        repeat (20) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        check_eq("pre_rst.dig", {4'h0, dig_obs}, 8'h0D);
        RST_N = 1'b0;
        #1;
        check_eq("async_rst.dig", {4'h0, dig_obs}, 8'h0F);
        check_eq("async_rst.seg", seg_obs, 8'hFF);
        check_eq("async_rst.frame", {7'h0, bus.FRAME}, 8'h00);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        run_frame("post_rst0", 20'h0, 0, -1, 20'h0, -1, 20'h0, -1, 1'b0);
        run_frame("post_rst1", 20'h0, 0, -1, 20'h0, -1, 20'h0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display on the robot board. It sequences the active-low digit selects D1–D4 and the active-low segment lines SEG_A–SEG_P, showing a latched 16-bit hex status value. When ERRO is raised, it overrides the value with the error pattern ("E" on D1, D2–D4 dark). Value updates and error entry/exit are applied only at frame boundaries, so the display never tears.

## Interface
Parameters:
- PRESCALE, 50000: clock cycles per digit slot (50 MHz → 1 kHz slot, 250 Hz frame); legal ≥ 4.
- BLANK_CYC, 2: cycles at the start of each slot with all digits off (anti-ghosting); legal 1..PRESCALE-2.
- BLINK_FRAMES, 64: frames per error on/off phase; used only with the blink macro.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- ERRO  in  1  asynchronous error level from robot core.
- LOAD  in  1  one-cycle strobe; captures VALUE and DP_IN into the pending register.
- VALUE  in  16  four hex nibbles; [15:12] → D1 … [3:0] → D4.
- DP_IN  in  4  decimal points; bit 3 → D1 … bit 0 → D4; 1 = lit.
- D1, D2, D3, D4  out  1 each  digit select, active-low.
- SEG_A … SEG_G, SEG_P  out  1 each  segments, active-low.
- FRAME  out  1  one-cycle pulse at each frame start.

## Operation
- Reset: D1–D4 = 1, all SEG_* = 1, FRAME = 0, slot counter = 0, digit index = 0 (D1), pending = shadow = 0, error mode off, synchronizer cleared.
- Slot counter counts 0..PRESCALE-1 and wraps. The digit index increments on wrap (0→1→2→3→0).
- Frame start is the cycle in which the counter wraps with index 3→0. At frame start:
  - shadow <= LOAD ? {VALUE,DP_IN} : pending. A LOAD coinciding with frame start wins.
  - error mode <= synchronized ERRO.
  - FRAME pulses.
- LOAD at any other time updates pending only; the displayed value is unchanged until the next frame start. Multiple LOADs within one frame: the last one wins.
- ERRO passes through a 2-flop synchronizer.
- Per slot, digit index i:
  - Counter < BLANK_CYC: all D* = 1. Segments hold the new digit's pattern.
  - Otherwise: D(i+1) = 0, others = 1.
- Normal mode segments: hex decode of shadow nibble i, standard 0–9, A, b, C, d, E, F, active-low. SEG_P = ~DP bit (3-i).
- Error mode:
  - Slot 0 drives "E": SEG_A, D, E, F, G = 0; SEG_B, C, P = 1; D1 low after blanking.
  - Slots 1–3 keep D2–D4 = 1 and all segments = 1.
  - Scan timing is unchanged, so brightness matches normal mode.
- Leaving error mode (ERRO low at a frame start) restores the shadow value immediately; the pending value is not lost.

## Timing
- All outputs are registered. Digit select falls in the cycle after the counter reaches BLANK_CYC and rises in the cycle after the counter wraps.
- Frame period = 4·PRESCALE cycles. Each digit is on for PRESCALE-BLANK_CYC cycles per frame.
- LOAD → displayed: at most 4·PRESCALE+1 cycles.
- ERRO edge → display change: 2 synchronizer cycles plus up to 4·PRESCALE+1 cycles.
- FRAME is high in the cycle after the frame-start wrap.
- RST_N assertion mid-frame forces all outputs to the reset values asynchronously. Scanning restarts at D1, counter 0, on the first clock after release.

## Configuration
- DISP_BLINK_ERR_EN defined:
  - In error mode, the "E" pattern alternates BLINK_FRAMES frames visible, then BLINK_FRAMES frames dark (D1 held high).
  - The blink counter resets on error-mode entry, and the first phase is visible.
- DISP_BLINK_ERR_EN undefined: the error pattern is steady, and no blink counter is synthesized.

## Test plan
Use PRESCALE=8, BLANK_CYC=2, BLINK_FRAMES=2.
- Reset then release, no LOAD → FRAME every 32 cycles; D1..D4 each low 6 cycles per slot in order; segments = "0" pattern (SEG_G=1, others 0).
- LOAD VALUE=16'h12AF, DP_IN=4'b0100 mid-frame → unchanged until next FRAME; then D1 "1", D2 "2" with SEG_P=0, D3 "A", D4 "F".
- LOAD in the exact frame-start cycle with 16'h3333, while pending holds 16'h5555 → "3333" shown that frame.
- ERRO raised for 100 cycles → at the first FRAME after 2 sync cycles, D1 shows SEG_A/D/E/F/G=0 and B/C/P=1; D2–D4 stay 1. After ERRO falls, the next frame restores the shadow value.
- RST_N pulsed low during slot 2 → all outputs 1 within the same cycle; restart at D1, counter 0; shadow cleared to 0.
- With DISP_BLINK_ERR_EN and ERRO held → "E" visible 2 frames, dark 2 frames, repeating. Without the macro → steady.
